fetch_stage: RTL and testbench

//  IF stage directly upstream of ID. Owns the fetch PC and issues in-order requests to instruction memory.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_fifo.sv | 46 ++++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, reset constants, FSM encodings and fetch buffer entry type
package fetch_stage_pkg;
  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0;
  typedef enum logic [1:0] {
    FETCH_ST_BOOT  = 2'd0,
    FETCH_ST_RUN   = 2'd1,
    FETCH_ST_FLUSH = 2'd2
  } fetchStateT;
  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
  } fetchEntryT;
endpackage

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: synchronous {pc, instr} buffer between imem responses and the ID register
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  fetchEntryT                   din,
  output fetchEntryT                   dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  fetchEntryT mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop) rdPtr <= nextPtr(rdPtr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wrPtr] <= din;
  end
  assign dout  = mem[rdPtr];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage feeding ID through a credit-limited fetch buffer; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallD,
  input  logic                  redirect,
  input  logic [WORD_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [WORD_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] imem_rsp_data,
  output logic [WORD_WIDTH-1:0] pcF,
  output logic [WORD_WIDTH-1:0] instrD,
  output logic [WORD_WIDTH-1:0] pcD,
  output logic                  validD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_redirect_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  fetchStateT state, stateNext;
  logic [WORD_WIDTH-1:0] rspPc;
  logic [CW-1:0] outstanding, outstandingNext, dropCnt, dropCntNext, occ;
  logic redirectAcc, reqFire, dropping, push, pop, fifoEmpty, fifoFull;
  fetchEntryT head;
  assign redirectAcc = redirect & ~stallD & validD;
  // Credits cover both buffered words and words still in flight, so a response always has a slot
  assign imem_req_valid = (state != FETCH_ST_BOOT) && !redirectAcc &&
                          (({1'b0, occ} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr = pcF;
  assign reqFire = imem_req_valid & imem_req_ready;
  assign dropping = imem_rsp_valid && dropCnt != '0;
  assign push = imem_rsp_valid && dropCnt == '0 && !redirectAcc;
  assign pop = !stallD && !redirectAcc && !fifoEmpty;
  assign outstandingNext = outstanding + CW'(reqFire) - CW'(imem_rsp_valid);
  assign dropCntNext = redirectAcc ? outstandingNext : dropCnt - CW'(dropping);
  always_comb begin
    stateNext = state;
    stateNext = (state == FETCH_ST_BOOT || dropCntNext == '0) ? FETCH_ST_RUN : FETCH_ST_FLUSH;
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .clear(redirectAcc),
    .din  ('{pc: rspPc, instr: imem_rsp_data}),
    .dout (head),
    .full (fifoFull),
    .empty(fifoEmpty),
    .count(occ)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH_ST_BOOT;
      pcF         <= RESET_PC;
      rspPc       <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
      instrD      <= NOP_INSTR;
      pcD         <= '0;
      validD      <= 1'b0;
    end else begin
      state       <= stateNext;
      outstanding <= outstandingNext;
      dropCnt     <= dropCntNext;
      pcF         <= redirectAcc ? redirect_pc : reqFire ? pcF + 32'd4 : pcF;
      rspPc       <= redirectAcc ? redirect_pc : push ? rspPc + 32'd4 : rspPc;
      if (!stallD) begin
        instrD <= pop ? head.instr : NOP_INSTR;
        validD <= pop;
        if (pop) pcD <= head.pc;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (stallD && validD) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirectAcc) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif
  assert property (@(posedge clk) disable iff (!rst) !(push && fifoFull && !pop));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench with an in-order variable-latency imem model
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  logic clk = 0, rst = 0, stallD = 0, redirect = 0, imem_req_ready = 1, imem_rsp_valid = 0;
  logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
  logic imem_req_valid, validD;
  logic [31:0] imem_req_addr, pcF, instrD, pcD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_redirect_cnt;
  int expStall = 0, expRedir = 0;
`endif
  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallD(stallD), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pcF(pcF), .instrD(instrD), .pcD(pcD), .validD(validD)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  typedef struct {logic [31:0] addr; int due;} pendT;
  pendT pend[$];
  logic [63:0] expQ[$];
  int checks = 0, errors = 0, lat = 1, edgeNum = 0;
  logic newDel = 0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: sample pre-edge at negedge, then score D and drive the imem response after the edge
  task automatic tick();
    logic fire, redAcc, upd, hValid;
    logic [31:0] addr, hPc, hInstr;
    logic [63:0] e;
    @(negedge clk);
    fire = imem_req_valid & imem_req_ready;
    addr = imem_req_addr;
    redAcc = redirect & !stallD & validD;
    upd = !stallD;
    hValid = validD; hPc = pcD; hInstr = instrD;
    if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
`ifdef FETCH_PERF_CNT_EN
    if (rst && stallD && validD) expStall++;
    if (rst && redAcc) expRedir++;
`endif
    @(posedge clk); #1;
    edgeNum++;
    newDel = 0;
    if (!rst) begin
      imem_rsp_valid = 0;
      return;
    end
    if (!upd) begin
      checks++;
      if ({validD, pcD, instrD} !== {hValid, hPc, hInstr}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b pc=%h i=%h want v=%b pc=%h i=%h", validD, pcD, instrD, hValid, hPc, hInstr);
      end
    end else if (redAcc) begin
      expQ.delete();
      checks++;
      if (validD !== 1'b0 || instrD !== 32'h0) begin
        errors++;
        $display("FAIL redirect_bubble: got v=%b i=%h want v=0 i=0", validD, instrD);
      end
    end else if (validD) begin
      newDel = 1;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_delivery: got pc=%h i=%h want none", pcD, instrD);
      end else begin
        e = expQ.pop_front();
        if ({pcD, instrD} !== e) begin
          errors++;
          $display("FAIL delivery: got pc=%h i=%h want pc=%h i=%h", pcD, instrD, e[63:32], e[31:0]);
        end
      end
    end
    if (fire) begin
      expQ.push_back({addr, memData(addr)});
      pend.push_back('{addr, edgeNum + lat - 1});
    end
    if (pend.size() > 0 && pend[0].due <= edgeNum) begin
      imem_rsp_valid = 1;
      imem_rsp_data = memData(pend[0].addr);
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = 0;
    end
  endtask

  task automatic runUntilDel(input int maxc, output logic got);
    got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      tick();
      got = newDel;
    end
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    checks++;
    if (pcF !== 32'h3000 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pc: got pcF=%h rv=%b want 3000 0", pcF, imem_req_valid);
    end
    checks++;
    if (validD !== 1'b0 || pcD !== 32'h0 || instrD !== 32'h0) begin
      errors++; $display("FAIL reset_d: got v=%b pc=%h i=%h want 0 0 0", validD, pcD, instrD);
    end
    rst = 1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL boot_noreq: got %b want 0", imem_req_valid);
    end
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3000) begin
      errors++; $display("FAIL first_req: got v=%b a=%h want 1 3000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_latency1();
    logic ok;
    lat = 1;
    for (int k = 0; k < 3; k++) begin
      runUntilDel(20, ok);
      checks++;
      if (!ok || pcD !== 32'h3000 + 32'(4 * k)) begin
        errors++; $display("FAIL seq_pc%0d: got ok=%b pc=%h want %h", k, ok, pcD, 32'h3000 + 32'(4 * k));
      end
    end
    repeat (10) tick();
  endtask

  task automatic test_stall();
    logic ok;
    logic [31:0] held;
    runUntilDel(20, ok);
    held = pcD;
    stallD = 1;
    repeat (5) tick();
    checks++;
    if (!ok || pcD !== held || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL stall_credit: got ok=%b pc=%h rv=%b want 1 %h 0", ok, pcD, imem_req_valid, held);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd5) begin
      errors++; $display("FAIL perf_stall5: got %0d want 5", perf_stall_cnt);
    end
`endif
    stallD = 0;
    repeat (10) tick();
  endtask

  task automatic test_redirect_flush();
    logic found, ok;
    lat = 3;
    repeat (10) tick();
    imem_req_ready = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = validD && expQ.size() == 0;
    end
    stallD = 1;
    imem_req_ready = 1;
    for (int i = 0; i < 10 && found && pend.size() != 2; i++) tick();
    checks++;
    if (!found || pend.size() != 2 || validD !== 1'b1) begin
      errors++; $display("FAIL flush_setup: got found=%b inflight=%0d v=%b want 1 2 1", found, pend.size(), validD);
    end
    stallD = 0;
    redirect = 1;
    redirect_pc = 32'h3100;
    tick();
    redirect = 0;
    checks++;
    if (pcF !== 32'h3100 || dut.state !== FETCH_ST_FLUSH) begin
      errors++; $display("FAIL redirect_flush: got pcF=%h st=%0d want 3100 %0d", pcF, dut.state, FETCH_ST_FLUSH);
    end
    runUntilDel(30, ok);
    checks++;
    if (!ok || pcD !== 32'h3100 || dut.state !== FETCH_ST_RUN) begin
      errors++; $display("FAIL redirect_target: got ok=%b pc=%h st=%0d want 1 3100 %0d", ok, pcD, dut.state, FETCH_ST_RUN);
    end
    repeat (10) tick();
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_redirect_cnt !== 32'd1 || perf_stall_cnt !== 32'(expStall)) begin
      errors++; $display("FAIL perf_counts: got s=%0d r=%0d want s=%0d r=1", perf_stall_cnt, perf_redirect_cnt, expStall);
    end
`endif
  endtask

  task automatic test_redirect_ignored();
    logic ok, found;
    logic [31:0] pre;
    lat = 1;
    runUntilDel(20, ok);
    imem_req_ready = 0;
    stallD = 1;
    redirect = 1;
    redirect_pc = 32'h5000;
    pre = pcF;
    tick();
    redirect = 0;
    stallD = 0;
    checks++;
    if (!ok || pcF !== pre) begin
      errors++; $display("FAIL redirect_stalled: got ok=%b pcF=%h want 1 %h", ok, pcF, pre);
    end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = !validD;
    end
    pre = pcF;
    redirect = 1;
    tick();
    redirect = 0;
    checks++;
    if (!found || pcF !== pre) begin
      errors++; $display("FAIL redirect_bubble_ign: got found=%b pcF=%h want 1 %h", found, pcF, pre);
    end
    imem_req_ready = 1;
    repeat (10) tick();
  endtask

  task automatic test_req_hold();
    logic [31:0] pre;
    lat = 1;
    repeat (8) tick();
    imem_req_ready = 0;
    pre = pcF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pcF !== pre || imem_req_addr !== pre) begin
        errors++; $display("FAIL req_stable%0d: got pcF=%h a=%h want %h", i, pcF, imem_req_addr, pre);
      end
    end
    checks++;
    if (imem_req_valid !== 1'b1 || validD !== 1'b0) begin
      errors++; $display("FAIL req_held: got rv=%b v=%b want 1 0", imem_req_valid, validD);
    end
    imem_req_ready = 1;
    repeat (10) tick();
  endtask

  task automatic test_async_reset();
    logic ok;
    repeat (5) tick();
    #3 rst = 0;
    #1;
    checks++;
    if (pcF !== 32'h3000 || validD !== 1'b0 || pcD !== 32'h0 || instrD !== 32'h0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pcF=%h v=%b pc=%h i=%h rv=%b", pcF, validD, pcD, instrD, imem_req_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_redirect_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_reset: got s=%0d r=%0d want 0 0", perf_stall_cnt, perf_redirect_cnt);
    end
    expStall = 0;
    expRedir = 0;
`endif
    expQ.delete();
    pend.delete();
    imem_rsp_valid = 0;
    tick(); tick();
    rst = 1;
    runUntilDel(20, ok);
    checks++;
    if (!ok || pcD !== 32'h3000) begin
      errors++; $display("FAIL refetch: got ok=%b pc=%h want 1 3000", ok, pcD);
    end
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_latency1();
    test_stall();
    test_redirect_flush();
    test_redirect_ignored();
    test_req_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
